// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared definitions for the RGB -> YUV 4:2:2 encoder.
//
// Contents:
//   - encoder_state_type : encoder FSM state encoding (one cycle per state)
//   - coef_sel_type      : conversion selector for the shared MAC (Y/U/V)
//   - *_BASE_DEFAULT     : default SRAM word addresses of the planes
//   - conversion coefficients (16.16 fixed point) and plane offsets
//   - pair_avg()         : rounded average of two 8-bit channel values
package m1_pkg;

    localparam logic [17:0] Y_BASE_DEFAULT   = 18'd0;
    localparam logic [17:0] U_BASE_DEFAULT   = 18'd38400;
    localparam logic [17:0] V_BASE_DEFAULT   = 18'd57600;
    localparam logic [17:0] RGB_BASE_DEFAULT = 18'd146944;

    typedef enum logic [4:0] {
        S_IDLE,
        S_RD_0, S_RD_1, S_RD_2, S_RD_3, S_RD_4, S_RD_5,
        S_RD_WAIT_0, S_RD_WAIT_1,
        S_CALC_Y0, S_CALC_Y1, S_CALC_Y2, S_CALC_Y3,
        S_CALC_U0, S_CALC_V0, S_CALC_U1, S_CALC_V1,
        S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V,
        S_DONE
    } encoder_state_type;

    typedef enum logic [1:0] {
        COEF_Y,
        COEF_U,
        COEF_V
    } coef_sel_type;

    localparam logic signed [31:0] Y_COEF_R =  32'sd16843;
    localparam logic signed [31:0] Y_COEF_G =  32'sd33030;
    localparam logic signed [31:0] Y_COEF_B =  32'sd6423;
    localparam logic signed [31:0] U_COEF_R = -32'sd9699;
    localparam logic signed [31:0] U_COEF_G = -32'sd19071;
    localparam logic signed [31:0] U_COEF_B =  32'sd28770;
    localparam logic signed [31:0] V_COEF_R =  32'sd28770;
    localparam logic signed [31:0] V_COEF_G = -32'sd24117;
    localparam logic signed [31:0] V_COEF_B = -32'sd4653;

    localparam logic signed [31:0] Y_OFFSET   = 32'sd1048576;   // 16 << 16
    localparam logic signed [31:0] UV_OFFSET  = 32'sd8388608;   // 128 << 16
    localparam logic signed [31:0] ROUND_BIAS = 32'sd32768;     // half LSB before >>> 16

    // (a + b + 1) >> 1 with a 9-bit intermediate so 255+255+1 does not wrap.
    function automatic logic [7:0] pair_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

endpackage

// File: rtl/rgb_to_yuv_encoder_if.sv
// SRAM port bundle used by the encoder.
//
// Signals:
//   SRAM_address    [17:0] word address
//   SRAM_read_data  [15:0] read data, valid two cycles after its address
//   SRAM_write_data [15:0] write data
//   SRAM_we_n              0 = write this cycle
// Modports:
//   master : the encoder (drives address / write data / we_n)
//   slave  : the SRAM or SRAM model (drives read data)
interface rgb_to_yuv_encoder_if;

    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (
        output SRAM_address,
        output SRAM_write_data,
        output SRAM_we_n,
        input  SRAM_read_data
    );

    modport slave (
        input  SRAM_address,
        input  SRAM_write_data,
        input  SRAM_we_n,
        output SRAM_read_data
    );

endinterface

// File: rtl/rgb_to_yuv_encoder_mac.sv
// Combinational colour-space conversion for one output component.
// Three signed 32-bit multipliers, sum with offset, round, >>> 16 and clip
// to 0..255. The coefficient set is chosen by coef_sel.
//
// Ports:
//   coef_sel in  : COEF_Y / COEF_U / COEF_V
//   r_in     in 8: red channel
//   g_in     in 8: green channel
//   b_in     in 8: blue channel
//   pix_out  out 8: clipped result
module rgb_to_yuv_mac
    import m1_pkg::*;
(
    input  coef_sel_type coef_sel,
    input  logic [7:0]   r_in,
    input  logic [7:0]   g_in,
    input  logic [7:0]   b_in,
    output logic [7:0]   pix_out
);

    logic signed [31:0] coef_r;
    logic signed [31:0] coef_g;
    logic signed [31:0] coef_b;
    logic signed [31:0] offset;
    logic signed [31:0] prod_r;
    logic signed [31:0] prod_g;
    logic signed [31:0] prod_b;
    logic signed [31:0] sum;
    logic signed [31:0] scaled;

    always_comb begin
        coef_r = Y_COEF_R;
        coef_g = Y_COEF_G;
        coef_b = Y_COEF_B;
        offset = Y_OFFSET;
        case (coef_sel)
            COEF_U: begin
                coef_r = U_COEF_R;
                coef_g = U_COEF_G;
                coef_b = U_COEF_B;
                offset = UV_OFFSET;
            end
            COEF_V: begin
                coef_r = V_COEF_R;
                coef_g = V_COEF_G;
                coef_b = V_COEF_B;
                offset = UV_OFFSET;
            end
            default: ;
        endcase
    end

    assign prod_r = coef_r * $signed({24'd0, r_in});
    assign prod_g = coef_g * $signed({24'd0, g_in});
    assign prod_b = coef_b * $signed({24'd0, b_in});
    assign sum    = prod_r + prod_g + prod_b + offset + ROUND_BIAS;
    assign scaled = sum >>> 16;

    always_comb begin
        if (scaled < 32'sd0) begin
            pix_out = 8'd0;
        end else if (scaled > 32'sd255) begin
            pix_out = 8'd255;
        end else begin
            pix_out = scaled[7:0];
        end
    end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// RGB -> YUV 4:2:2 encoder. Reads packed RGB from SRAM (2 pixels per 3
// words), converts 4 pixels per group to Y and one U/V per pixel pair, and
// writes Y, U and V as packed byte planes (even element in the high byte).
// Each group is 6 reads, 2 read-latency waits, 8 conversions and 4 writes:
// 20 cycles. The encoder owns the SRAM port for the whole pass.
//
// Build option:
//   CHROMA_AVG_EN defined   : chroma from the rounded average of each pair
//   CHROMA_AVG_EN undefined : chroma from the even pixel of each pair
//
// Ports:
//   Clock  in  : clock
//   Resetn in  : asynchronous active-low reset (aborts a pass immediately)
//   Enable in  : start request, only looked at in S_IDLE
//   sram       : SRAM bundle (master side)
//   Done   out : high for the single S_DONE cycle at the end of a pass
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | waiting for Enable, bus idle
// S_RD_0..5    | read address RGB_BASE+rgb_count+k on the bus
// S_RD_WAIT_0/1| last two read words arrive (2-cycle SRAM latency)
// S_CALC_Y0..3 | Y of pixel 0..3 through the shared MAC
// S_CALC_U0/V0 | chroma of pixel pair 0/1
// S_CALC_U1/V1 | chroma of pixel pair 2/3
// S_WR_Y0/Y1   | write {Y0,Y1} / {Y2,Y3}
// S_WR_U/V     | write {U01,U23} / {V01,V23}; S_WR_V ends the group
// S_DONE       | Done pulse, back to S_IDLE
module rgb_to_yuv_encoder
    import m1_pkg::*;
#(
    parameter logic [17:0] Y_BASE       = Y_BASE_DEFAULT,
    parameter logic [17:0] U_BASE       = U_BASE_DEFAULT,
    parameter logic [17:0] V_BASE       = V_BASE_DEFAULT,
    parameter logic [17:0] RGB_BASE     = RGB_BASE_DEFAULT,
    parameter int          IMAGE_WIDTH  = 320,
    parameter int          IMAGE_HEIGHT = 240
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic                        Enable,
    rgb_to_yuv_encoder_if.master        sram,
    output logic                        Done
);

    localparam int          NUM_GROUPS = IMAGE_WIDTH * IMAGE_HEIGHT / 4;
    localparam logic [17:0] LAST_GROUP = 18'(NUM_GROUPS - 1);

    encoder_state_type state_q, state_d;

    // grp_left counts down the groups still to be started after this one.
    logic [17:0]       rgb_count_q, rgb_count_d;
    logic [17:0]       y_count_q,   y_count_d;
    logic [17:0]       uv_count_q,  uv_count_d;
    logic [17:0]       grp_left_q,  grp_left_d;

    logic [5:0][15:0]  rd_buf_q, rd_buf_d;
    logic [3:0][7:0]   y_q, y_d;
    logic [1:0][7:0]   u_q, u_d;
    logic [1:0][7:0]   v_q, v_d;

    logic [17:0]       addr_q,  addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              we_n_q,  we_n_d;
    logic              done_q,  done_d;

    logic [3:0][7:0]   pix_r, pix_g, pix_b;
    logic [1:0][7:0]   chroma_r, chroma_g, chroma_b;

    coef_sel_type      mac_sel;
    logic [7:0]        mac_r, mac_g, mac_b;
    logic [7:0]        mac_out;

    // Unpack the six buffered words {R0,G0},{B0,R1},{G1,B1},{R2,G2},{B2,R3},{G3,B3}.
    assign pix_r[0] = rd_buf_q[0][15:8];
    assign pix_g[0] = rd_buf_q[0][7:0];
    assign pix_b[0] = rd_buf_q[1][15:8];
    assign pix_r[1] = rd_buf_q[1][7:0];
    assign pix_g[1] = rd_buf_q[2][15:8];
    assign pix_b[1] = rd_buf_q[2][7:0];
    assign pix_r[2] = rd_buf_q[3][15:8];
    assign pix_g[2] = rd_buf_q[3][7:0];
    assign pix_b[2] = rd_buf_q[4][15:8];
    assign pix_r[3] = rd_buf_q[4][7:0];
    assign pix_g[3] = rd_buf_q[5][15:8];
    assign pix_b[3] = rd_buf_q[5][7:0];

`ifdef CHROMA_AVG_EN
    assign chroma_r[0] = pair_avg(pix_r[0], pix_r[1]);
    assign chroma_g[0] = pair_avg(pix_g[0], pix_g[1]);
    assign chroma_b[0] = pair_avg(pix_b[0], pix_b[1]);
    assign chroma_r[1] = pair_avg(pix_r[2], pix_r[3]);
    assign chroma_g[1] = pair_avg(pix_g[2], pix_g[3]);
    assign chroma_b[1] = pair_avg(pix_b[2], pix_b[3]);
`else
    assign chroma_r[0] = pix_r[0];
    assign chroma_g[0] = pix_g[0];
    assign chroma_b[0] = pix_b[0];
    assign chroma_r[1] = pix_r[2];
    assign chroma_g[1] = pix_g[2];
    assign chroma_b[1] = pix_b[2];
`endif

    rgb_to_yuv_mac u_mac (
        .coef_sel (mac_sel),
        .r_in     (mac_r),
        .g_in     (mac_g),
        .b_in     (mac_b),
        .pix_out  (mac_out)
    );

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (Enable) state_d = S_RD_0;
            S_RD_0:      state_d = S_RD_1;
            S_RD_1:      state_d = S_RD_2;
            S_RD_2:      state_d = S_RD_3;
            S_RD_3:      state_d = S_RD_4;
            S_RD_4:      state_d = S_RD_5;
            S_RD_5:      state_d = S_RD_WAIT_0;
            S_RD_WAIT_0: state_d = S_RD_WAIT_1;
            S_RD_WAIT_1: state_d = S_CALC_Y0;
            S_CALC_Y0:   state_d = S_CALC_Y1;
            S_CALC_Y1:   state_d = S_CALC_Y2;
            S_CALC_Y2:   state_d = S_CALC_Y3;
            S_CALC_Y3:   state_d = S_CALC_U0;
            S_CALC_U0:   state_d = S_CALC_V0;
            S_CALC_V0:   state_d = S_CALC_U1;
            S_CALC_U1:   state_d = S_CALC_V1;
            S_CALC_V1:   state_d = S_WR_Y0;
            S_WR_Y0:     state_d = S_WR_Y1;
            S_WR_Y1:     state_d = S_WR_U;
            S_WR_U:      state_d = S_WR_V;
            S_WR_V:      state_d = (grp_left_q == 18'd0) ? S_DONE : S_RD_0;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Shared MAC operand select: one conversion per CALC state.
    always_comb begin
        mac_sel = COEF_Y;
        mac_r   = pix_r[0];
        mac_g   = pix_g[0];
        mac_b   = pix_b[0];
        case (state_q)
            S_CALC_Y1: begin
                mac_r = pix_r[1]; mac_g = pix_g[1]; mac_b = pix_b[1];
            end
            S_CALC_Y2: begin
                mac_r = pix_r[2]; mac_g = pix_g[2]; mac_b = pix_b[2];
            end
            S_CALC_Y3: begin
                mac_r = pix_r[3]; mac_g = pix_g[3]; mac_b = pix_b[3];
            end
            S_CALC_U0: begin
                mac_sel = COEF_U;
                mac_r = chroma_r[0]; mac_g = chroma_g[0]; mac_b = chroma_b[0];
            end
            S_CALC_V0: begin
                mac_sel = COEF_V;
                mac_r = chroma_r[0]; mac_g = chroma_g[0]; mac_b = chroma_b[0];
            end
            S_CALC_U1: begin
                mac_sel = COEF_U;
                mac_r = chroma_r[1]; mac_g = chroma_g[1]; mac_b = chroma_b[1];
            end
            S_CALC_V1: begin
                mac_sel = COEF_V;
                mac_r = chroma_r[1]; mac_g = chroma_g[1]; mac_b = chroma_b[1];
            end
            default: ;
        endcase
    end

    // Output / datapath logic. Bus outputs are computed from the state being
    // entered so that address, data and we_n are registered in that state.
    always_comb begin
        rgb_count_d = rgb_count_q;
        y_count_d   = y_count_q;
        uv_count_d  = uv_count_q;
        grp_left_d  = grp_left_q;
        rd_buf_d    = rd_buf_q;
        y_d         = y_q;
        u_d         = u_q;
        v_d         = v_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_n_d      = 1'b1;
        done_d      = 1'b0;

        if (state_q == S_IDLE && state_d == S_RD_0) begin
            rgb_count_d = 18'd0;
            y_count_d   = 18'd0;
            uv_count_d  = 18'd0;
            grp_left_d  = LAST_GROUP;
        end else if (state_q == S_WR_V && state_d == S_RD_0) begin
            rgb_count_d = rgb_count_q + 18'd6;
            y_count_d   = y_count_q + 18'd2;
            uv_count_d  = uv_count_q + 18'd1;
            grp_left_d  = grp_left_q - 18'd1;
        end

        // Read data trails its address by two cycles.
        case (state_q)
            S_RD_2:      rd_buf_d[0] = sram.SRAM_read_data;
            S_RD_3:      rd_buf_d[1] = sram.SRAM_read_data;
            S_RD_4:      rd_buf_d[2] = sram.SRAM_read_data;
            S_RD_5:      rd_buf_d[3] = sram.SRAM_read_data;
            S_RD_WAIT_0: rd_buf_d[4] = sram.SRAM_read_data;
            S_RD_WAIT_1: rd_buf_d[5] = sram.SRAM_read_data;
            S_CALC_Y0:   y_d[0] = mac_out;
            S_CALC_Y1:   y_d[1] = mac_out;
            S_CALC_Y2:   y_d[2] = mac_out;
            S_CALC_Y3:   y_d[3] = mac_out;
            S_CALC_U0:   u_d[0] = mac_out;
            S_CALC_V0:   v_d[0] = mac_out;
            S_CALC_U1:   u_d[1] = mac_out;
            S_CALC_V1:   v_d[1] = mac_out;
            default: ;
        endcase

        case (state_d)
            S_RD_0: addr_d = RGB_BASE + rgb_count_d;
            S_RD_1: addr_d = RGB_BASE + rgb_count_d + 18'd1;
            S_RD_2: addr_d = RGB_BASE + rgb_count_d + 18'd2;
            S_RD_3: addr_d = RGB_BASE + rgb_count_d + 18'd3;
            S_RD_4: addr_d = RGB_BASE + rgb_count_d + 18'd4;
            S_RD_5: addr_d = RGB_BASE + rgb_count_d + 18'd5;
            S_WR_Y0: begin
                addr_d  = Y_BASE + y_count_d;
                wdata_d = {y_q[0], y_q[1]};
                we_n_d  = 1'b0;
            end
            S_WR_Y1: begin
                addr_d  = Y_BASE + y_count_d + 18'd1;
                wdata_d = {y_q[2], y_q[3]};
                we_n_d  = 1'b0;
            end
            S_WR_U: begin
                addr_d  = U_BASE + uv_count_d;
                wdata_d = {u_q[0], u_q[1]};
                we_n_d  = 1'b0;
            end
            S_WR_V: begin
                addr_d  = V_BASE + uv_count_d;
                wdata_d = {v_q[0], v_q[1]};
                we_n_d  = 1'b0;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rgb_count_q <= 18'd0;
            y_count_q   <= 18'd0;
            uv_count_q  <= 18'd0;
            grp_left_q  <= 18'd0;
            rd_buf_q    <= '0;
            y_q         <= '0;
            u_q         <= '0;
            v_q         <= '0;
            addr_q      <= 18'd0;
            wdata_q     <= 16'd0;
            we_n_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            rgb_count_q <= rgb_count_d;
            y_count_q   <= y_count_d;
            uv_count_q  <= uv_count_d;
            grp_left_q  <= grp_left_d;
            rd_buf_q    <= rd_buf_d;
            y_q         <= y_d;
            u_q         <= u_d;
            v_q         <= v_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            done_q      <= done_d;
        end
    end

    assign sram.SRAM_address    = addr_q;
    assign sram.SRAM_write_data = wdata_q;
    assign sram.SRAM_we_n       = we_n_q;
    assign Done                 = done_q;

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Testbench for rgb_to_yuv_encoder on a small 8x4 image (8 groups).
// The SRAM model returns a repeating two-pixel pattern for the RGB region
// (2-cycle read latency) and records writes into a small plane memory.
// Expected chroma depends on whether CHROMA_AVG_EN is defined.
`timescale 1ns/1ps
module tb_rgb_to_yuv_encoder;

    localparam logic [17:0] TB_Y_BASE   = 18'd100;
    localparam logic [17:0] TB_U_BASE   = 18'd200;
    localparam logic [17:0] TB_V_BASE   = 18'd300;
    localparam logic [17:0] TB_RGB_BASE = 18'd400;
    localparam int          TB_W        = 8;
    localparam int          TB_H        = 4;
    localparam int          NG          = TB_W * TB_H / 4;
    // Edges from the one that samples Enable to the one that raises Done.
    // Done falls one edge later, so a pass spans 20*NG+2 edges in total.
    localparam int          PASS_EDGES  = 20 * NG + 1;

`ifdef CHROMA_AVG_EN
    localparam logic [7:0] U_RK = 8'd109, V_RK = 8'd184;
    localparam logic [7:0] U_KR = 8'd109, V_KR = 8'd184;
    localparam logic [7:0] U_GB = 8'd147, V_GB = 8'd72;
`else
    localparam logic [7:0] U_RK = 8'd90,  V_RK = 8'd240;
    localparam logic [7:0] U_KR = 8'd128, V_KR = 8'd128;
    localparam logic [7:0] U_GB = 8'd54,  V_GB = 8'd34;
`endif

    typedef struct {
        logic [7:0] r0, g0, b0, r1, g1, b1;
        logic [7:0] ey0, ey1, eu, ev;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    logic clk;
    logic rst_n;
    logic enable;
    logic done;
    int   n_cmp;
    int   n_bad;

    rgb_to_yuv_encoder_if sram_if ();

    rgb_to_yuv_encoder #(
        .Y_BASE       (TB_Y_BASE),
        .U_BASE       (TB_U_BASE),
        .V_BASE       (TB_V_BASE),
        .RGB_BASE     (TB_RGB_BASE),
        .IMAGE_WIDTH  (TB_W),
        .IMAGE_HEIGHT (TB_H)
    ) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .Enable (enable),
        .sram   (sram_if),
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [15:0] cur_w [0:3];
    logic [15:0] wmem  [0:511];
    logic        clr_mem;
    int          wr_count;
    logic [15:0] rd_p1, rd_p2;
    wire  [17:0] rgb_off  = sram_if.SRAM_address - TB_RGB_BASE;
    wire  [17:0] off_mod3 = rgb_off % 18'd3;

    always @(posedge clk) begin
        rd_p1 <= (sram_if.SRAM_address >= TB_RGB_BASE) ? cur_w[off_mod3[1:0]] : 16'h0000;
        rd_p2 <= rd_p1;
        if (clr_mem) begin
            for (int i = 0; i < 512; i++) wmem[i] <= 16'hDEAD;
            wr_count <= 0;
        end else if (!sram_if.SRAM_we_n) begin
            if (sram_if.SRAM_address < 18'd512) wmem[sram_if.SRAM_address[8:0]] <= sram_if.SRAM_write_data;
            wr_count <= wr_count + 1;
        end
    end
    assign sram_if.SRAM_read_data = rd_p2;

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_pattern(input vec_t v);
        cur_w[0] = {v.r0, v.g0};
        cur_w[1] = {v.b0, v.r1};
        cur_w[2] = {v.g1, v.b1};
        cur_w[3] = 16'h0000;
    endtask

    task automatic clear_mem();
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
    endtask

    // mode 0: Enable for one edge; 1: Enable toggled during the pass; 2: held high.
    // Returns at the negedge where Done is seen high (or the bound expires).
    task automatic start_and_wait(input int mode, output int edges);
        bit seen;
        edges = 0;
        seen  = 1'b0;
        enable = 1'b1;
        while (!seen && edges < PASS_EDGES + 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) check("first_rd_addr", 32'(sram_if.SRAM_address), 32'(TB_RGB_BASE));
            if (mode == 1) enable = (edges < PASS_EDGES - 10) ? edges[1] : 1'b0;
            else if (mode == 0) enable = 1'b0;
            seen = done;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_planes(input vec_t v, input string tag);
        for (int g = 0; g < NG; g++) begin
            check($sformatf("%s_y%0d_w0", tag, g), 32'(wmem[int'(TB_Y_BASE) + 2*g]),     32'({v.ey0, v.ey1}));
            check($sformatf("%s_y%0d_w1", tag, g), 32'(wmem[int'(TB_Y_BASE) + 2*g + 1]), 32'({v.ey0, v.ey1}));
            check($sformatf("%s_u%0d", tag, g),    32'(wmem[int'(TB_U_BASE) + g]),       32'({v.eu, v.eu}));
            check($sformatf("%s_v%0d", tag, g),    32'(wmem[int'(TB_V_BASE) + g]),       32'({v.ev, v.ev}));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int  edges;
        int  d_edges;
        bit  hit;
        bit  seen;
        int  wr_at_reset;

        //            r0     g0     b0     r1     g1     b1     Y0     Y1     U      V
        vecs[0] = '{8'd255,8'd255,8'd255,8'd255,8'd255,8'd255, 8'd235,8'd235,8'd128,8'd128}; // white
        vecs[1] = '{8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,   8'd16, 8'd16, 8'd128,8'd128}; // black
        vecs[2] = '{8'd255,8'd0,  8'd0,  8'd255,8'd0,  8'd0,   8'd82, 8'd82, 8'd90, 8'd240}; // red
        vecs[3] = '{8'd0,  8'd0,  8'd255,8'd0,  8'd0,  8'd255, 8'd41, 8'd41, 8'd240,8'd110}; // blue
        vecs[4] = '{8'd255,8'd0,  8'd0,  8'd0,  8'd0,  8'd0,   8'd82, 8'd16, U_RK,  V_RK};   // red/black
        vecs[5] = '{8'd0,  8'd0,  8'd0,  8'd255,8'd0,  8'd0,   8'd16, 8'd82, U_KR,  V_KR};   // black/red
        vecs[6] = '{8'd0,  8'd255,8'd0,  8'd0,  8'd0,  8'd255, 8'd145,8'd41, U_GB,  V_GB};   // green/blue
        vecs[7] = '{8'd100,8'd150,8'd200,8'd100,8'd150,8'd200, 8'd137,8'd137,8'd157,8'd103}; // grey-blue

        n_cmp   = 0;
        n_bad   = 0;
        enable  = 1'b0;
        clr_mem = 1'b0;
        rst_n   = 1'b1;
        load_pattern(vecs[0]);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr",  32'(sram_if.SRAM_address),    32'd0);
        check("rst_wdata", 32'(sram_if.SRAM_write_data), 32'd0);
        check("rst_we_n",  32'(sram_if.SRAM_we_n),       32'd1);
        check("rst_done",  32'(done),                    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven passes.
        for (int vi = 0; vi < NV; vi++) begin
            load_pattern(vecs[vi]);
            clear_mem();
            start_and_wait(0, edges);
            check($sformatf("v%0d_pass_edges", vi), 32'(edges), 32'(PASS_EDGES));
            check($sformatf("v%0d_wr_count", vi), 32'(wr_count), 32'(4 * NG));
            check_planes(vecs[vi], $sformatf("v%0d", vi));
        end

        // Enable toggling mid-pass has no effect.
        load_pattern(vecs[6]);
        clear_mem();
        start_and_wait(1, edges);
        check("tog_pass_edges", 32'(edges), 32'(PASS_EDGES));
        check("tog_wr_count", 32'(wr_count), 32'(4 * NG));
        check_planes(vecs[6], "tog");

        // Enable held high: a second pass follows Done.
        load_pattern(vecs[7]);
        clear_mem();
        start_and_wait(2, edges);
        check("hold_pass1_edges", 32'(edges), 32'(PASS_EDGES));
        d_edges = 0;
        seen    = 1'b0;
        while (!seen && d_edges < PASS_EDGES + 40) begin
            @(posedge clk);
            d_edges++;
            @(negedge clk);
            if (d_edges == 1) check("hold_done_pulse", 32'(done), 32'd0);
            if (d_edges == 2) check("hold_restart_addr", 32'(sram_if.SRAM_address), 32'(TB_RGB_BASE));
            if (d_edges == 3) enable = 1'b0;
            seen = done;
        end
        check("hold_done_to_done", 32'(d_edges), 32'(20 * NG + 2));
        check("hold_wr_count", 32'(wr_count), 32'(8 * NG));
        check_planes(vecs[7], "hold");

        // Reset during group 5 S_WR_U aborts before the U write lands.
        load_pattern(vecs[2]);
        clear_mem();
        enable = 1'b1;
        hit    = 1'b0;
        for (int c = 0; c < PASS_EDGES + 40 && !hit; c++) begin
            @(negedge clk);
            enable = 1'b0;
            if (!sram_if.SRAM_we_n && sram_if.SRAM_address == TB_U_BASE + 18'd5) hit = 1'b1;
        end
        check("abort_found_wr_u5", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_addr",  32'(sram_if.SRAM_address),    32'd0);
        check("abort_wdata", 32'(sram_if.SRAM_write_data), 32'd0);
        check("abort_we_n",  32'(sram_if.SRAM_we_n),       32'd1);
        check("abort_done",  32'(done),                    32'd0);
        wr_at_reset = wr_count;
        check("abort_wr_before", 32'(wr_at_reset), 32'd22);
        repeat (3) @(negedge clk);
        check("abort_wr_after", 32'(wr_count), 32'd22);
        check("abort_u5_unwritten", 32'(wmem[int'(TB_U_BASE) + 5]), 32'h0000DEAD);
        check("abort_v5_unwritten", 32'(wmem[int'(TB_V_BASE) + 5]), 32'h0000DEAD);
        check("abort_y11_kept",     32'(wmem[int'(TB_Y_BASE) + 11]), 32'h00005252);
        check("abort_u4_kept",      32'(wmem[int'(TB_U_BASE) + 4]),  32'h00005A5A);
        rst_n = 1'b1;
        @(negedge clk);
        start_and_wait(0, edges);
        check("restart_pass_edges", 32'(edges), 32'(PASS_EDGES));
        check_planes(vecs[2], "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
